vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
//
// PURPOSE
// Shares one single-port 32-bit video RAM between two requesters: the video
// fetch engine and CPU byte writes. The video fetch engine issues one 32-bit
// plane-interleaved read every 16 pixels. CPU byte writes target 0x8000-0xFFFF.
// CPU writes are queued in a small FIFO, and video reads always win arbitration,
// so pixel fetch stays deterministic. The block sits between the CPU bus and
// video timing on one side and the external/BRAM video memory on the other.
//
// PARAMETERS
// FIFO_DEPTH  4   CPU write queue entries; power of 2, 2..16
// RD_LAT      2   RAM read latency, ram_rd cycle to ram_q valid; 1..4
//
// PORTS
// clk_ram    in   1   video RAM clock; single clock domain for the block
// reset_n    in   1   asynchronous, active-low reset
// vid_req    in   1   one-cycle pulse: fetch word at vid_addr
// vid_addr   in   13  word address {column[4:0], line[7:0]}
// vid_q      out  32  fetched word {plane3,plane2,plane1,plane0}; held
// vid_valid  out  1   one-cycle pulse: vid_q updated
// vid_miss   out  1   sticky: vid_req arrived while a read was still pending
// cpu_we     in   1   CPU memory write strobe, one cycle
// cpu_addr   in   16  CPU address; queued only if cpu_addr[15]=1
// cpu_din    in   8   CPU write data
// cpu_wait   out  1   FIFO full; a write presented now is dropped
// cpu_ovf    out  1   sticky: a write was dropped on full
// ram_addr   out  13  RAM word address
// ram_wdata  out  32  RAM write data
// ram_be     out  4   RAM byte enables, one-hot during writes
// ram_we     out  1   RAM write strobe, one cycle per write
// ram_rd     out  1   RAM read strobe, one cycle per read
// ram_q      in   32  RAM read data, valid RD_LAT cycles after ram_rd
//
// BEHAVIOUR
// - Reset values, asynchronous on reset_n low:
//   - state=IDLE; FIFO empty; vid_pend=0.
//   - All outputs 0, including vid_q, vid_miss and cpu_ovf.
// - Byte mapping:
//   - word = cpu_addr[12:0]; lane = cpu_addr[14:13].
//   - ram_be = 1<<lane; ram_wdata = {4{din}}.
// - FIFO:
//   - Push when cpu_we & cpu_addr[15] & !full. Entry = {word, lane, din}.
//   - cpu_wait = (count==FIFO_DEPTH), combinational.
//   - cpu_we with addr[15]=1 while full: write dropped, cpu_ovf<=1 (stays set
//     until reset).
//   - cpu_we with addr[15]=0: ignored, no flag.
//   - Push and pop in the same cycle: count unchanged. A pop does not unblock
//     a push in the same cycle, because full is sampled before the pop.
// - Video request latch:
//   - vid_req sets vid_pend and captures vid_addr.
//   - vid_req while vid_pend=1 or state=RD: the new address overwrites the
//     latch, vid_miss<=1, and one read serves the latest address.
// - FSM states, outputs registered:
//   - IDLE:
//     - If (vid_req|vid_pend): ram_rd<=1, ram_addr<=latched/current address,
//       clear vid_pend, go to RD with cnt=0.
//     - Else if FIFO not empty: pop, ram_we<=1, drive addr/be/wdata, go to WR.
//     - Else stay in IDLE.
//   - RD:
//     - ram_rd deasserts after one cycle. cnt increments each cycle.
//     - On cnt==RD_LAT-1 (the cycle ram_q is valid): vid_q<=ram_q,
//       vid_valid<=1, go to IDLE.
//   - WR: ram_we deasserts; go to IDLE. Exactly one RAM cycle per write.
// - Latency:
//   - vid_req at cycle N in IDLE: ram_rd high in N+1; vid_valid high in
//     N+2+RD_LAT.
//   - Worst case is 1 cycle later, when a WR was issued in cycle N.
//   - The bound must be <16 clk_ram cycles for RD_LAT<=4.
// - Priority:
//   - A video read is never delayed by more than one in-flight write.
//   - CPU writes drain only in IDLE slots with no video request.
// - No forwarding: a read may return data older than queued writes to the
//   same word. That staleness is one fetch at most and is accepted.
// - ram_be and ram_wdata are 0 when ram_we=0.
// - reset_n asserted mid-RD or mid-WR aborts immediately. No vid_valid is
//   produced and queued writes are lost.
//
// TESTING
// - Single write: cpu_we, addr=0xA005, din=0x5A.
//   -> WR cycle with ram_addr=0x0005, ram_be=4'b0010, ram_wdata=0x5A5A5A5A.
// - Read, RD_LAT=2: vid_req, vid_addr=0x1F00 at cycle 10; ram_q=0xDEADBEEF.
//   -> ram_rd at 11; vid_valid at 14 with vid_q=0xDEADBEEF.
// - Collision: FIFO has 1 entry, vid_req arrives in the same IDLE cycle.
//   -> read issued first, write issued right after vid_valid.
// - Full: 5 writes back-to-back with vid_req every cycle (FIFO_DEPTH=4).
//   -> cpu_wait=1 after the 4th write; 5th write dropped, cpu_ovf=1.
// - Overrun: two vid_req 1 cycle apart.
//   -> vid_miss=1; vid_valid carries data for the second address.
// - Reset mid-RD: assert reset_n low during RD.
//   -> all outputs 0, FIFO empty, state IDLE, no vid_valid.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port 32-bit video RAM between the video fetch engine
//   (32-bit plane-interleaved reads) and queued CPU byte writes. Video reads
//   always win arbitration. Writes drain only in idle slots.
//
// Parameters
//   FIFO_DEPTH  CPU write queue entries (power of 2, 2..16)
//   RD_LAT      RAM read latency, ram_rd cycle to ram_q valid (1..4)
//
// Ports
//   clk_ram, reset_n         clock, asynchronous active-low reset
//   vid_req/vid_addr         one-cycle fetch request, word address
//   vid_q/vid_valid          fetched word (held), one-cycle update pulse
//   vid_miss                 sticky: request arrived while a read was pending
//   cpu_we/cpu_addr/cpu_din  CPU write strobe, address, data (0x8000-0xFFFF)
//   cpu_wait/cpu_ovf         queue full, sticky dropped-write flag
//   ram_*                    registered RAM interface, ram_q read data in
module vram_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic        clk_ram,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic [31:0] vid_q,
    output logic        vid_valid,
    output logic        vid_miss,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_wait,
    output logic        cpu_ovf,
    output logic [12:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    output logic        ram_we,
    output logic        ram_rd,
    input  logic [31:0] ram_q
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 23;   // {word[12:0], lane[1:0], din[7:0]}
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t          r_state, w_state_nxt;

    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic            w_full, w_empty, w_push, w_pop;
    logic [EW-1:0]   w_head;

    logic            r_vid_pend, r_vid_miss, r_cpu_ovf;
    logic [12:0]     r_vid_lat;
    logic            w_rd_issue;

    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [31:0]     r_vid_q, w_vid_q_nxt;
    logic            r_vid_valid, w_vid_valid_nxt;
    logic [12:0]     r_ram_addr, w_ram_addr_nxt;
    logic [31:0]     r_ram_wdata, w_ram_wdata_nxt;
    logic [3:0]      r_ram_be, w_ram_be_nxt;
    logic            r_ram_we, w_ram_we_nxt;
    logic            r_ram_rd, w_ram_rd_nxt;

    // Full is taken from the registered count, so a same-cycle pop never
    // frees a slot for a push.
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = cpu_we & cpu_addr[15] & ~w_full;
    assign w_head  = r_mem[r_rptr];

    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_rd_issue      = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_vid_q_nxt     = r_vid_q;
        w_vid_valid_nxt = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = '0;
        w_ram_be_nxt    = '0;
        w_ram_we_nxt    = 1'b0;
        w_ram_rd_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (vid_req | r_vid_pend) begin
                    w_rd_issue     = 1'b1;
                    w_ram_rd_nxt   = 1'b1;
                    w_ram_addr_nxt = vid_req ? vid_addr : r_vid_lat;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_RD;
                end else if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_ram_we_nxt    = 1'b1;
                    w_ram_addr_nxt  = w_head[22:10];
                    w_ram_be_nxt    = 4'b0001 << w_head[9:8];
                    w_ram_wdata_nxt = {4{w_head[7:0]}};
                    w_state_nxt     = S_WR;
                end
            end
            S_RD: begin
                // cnt starts counting in the cycle after the ram_rd strobe,
                // so cnt==RD_LAT-1 lands on the cycle ram_q is valid.
                if (r_ram_rd) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CW'(RD_LAT - 1)) begin
                    w_vid_q_nxt     = ram_q;
                    w_vid_valid_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WR:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_ram) begin
        if (w_push) r_mem[r_wptr] <= {cpu_addr[12:0], cpu_addr[14:13], cpu_din};
    end

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_cpu_ovf   <= 1'b0;
            r_vid_pend  <= 1'b0;
            r_vid_lat   <= '0;
            r_vid_miss  <= 1'b0;
            r_cnt       <= '0;
            r_vid_q     <= '0;
            r_vid_valid <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_be    <= '0;
            r_ram_we    <= 1'b0;
            r_ram_rd    <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (cpu_we && cpu_addr[15] && w_full) r_cpu_ovf <= 1'b1;

            // A request while one is already waiting or in flight overwrites
            // the latch; the next read serves the latest address.
            if (vid_req) r_vid_lat <= vid_addr;
            if (vid_req && (r_vid_pend || r_state == S_RD)) r_vid_miss <= 1'b1;
            if (w_rd_issue)   r_vid_pend <= 1'b0;
            else if (vid_req) r_vid_pend <= 1'b1;

            r_cnt       <= w_cnt_nxt;
            r_vid_q     <= w_vid_q_nxt;
            r_vid_valid <= w_vid_valid_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_ram_be    <= w_ram_be_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_rd    <= w_ram_rd_nxt;
        end
    end

    assign vid_q     = r_vid_q;
    assign vid_valid = r_vid_valid;
    assign vid_miss  = r_vid_miss;
    assign cpu_wait  = w_full;
    assign cpu_ovf   = r_cpu_ovf;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_be    = r_ram_be;
    assign ram_we    = r_ram_we;
    assign ram_rd    = r_ram_rd;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed bench for vram_arbiter (FIFO_DEPTH=4, RD_LAT=2). A small RAM
//   model returns a per-address pattern exactly RD_LAT cycles after ram_rd
//   and zero otherwise.
module tb_vram_arbiter;

    logic        clk_ram = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = '0;
    logic [31:0] vid_q;
    logic        vid_valid, vid_miss;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_wait, cpu_ovf;
    logic [12:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we, ram_rd;
    logic [31:0] ram_q;

    int n_chk  = 0;
    int n_fail = 0;

    vram_arbiter #(.FIFO_DEPTH(4), .RD_LAT(2)) dut (
        .clk_ram(clk_ram), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_q(vid_q),
        .vid_valid(vid_valid), .vid_miss(vid_miss),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_wait(cpu_wait), .cpu_ovf(cpu_ovf),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_we(ram_we), .ram_rd(ram_rd), .ram_q(ram_q)
    );

    always #5 clk_ram = ~clk_ram;

    function automatic logic [31:0] pat(input logic [12:0] a);
        return (a == 13'h1F00) ? 32'hDEADBEEF : {8'hC0, 11'h0, a};
    endfunction

    // Two-stage read pipeline: data appears in the cycle RD_LAT=2 after ram_rd.
    logic [31:0] r_p1 = '0, r_p2 = '0;
    always @(posedge clk_ram) begin
        r_p1 <= ram_rd ? pat(ram_addr) : 32'h0;
        r_p2 <= r_p1;
    end
    assign ram_q = r_p2;

    task automatic step();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_q"},     vid_q, 32'h0);
        chk({tag, "_flags"},     {28'h0, vid_valid, vid_miss, cpu_wait, cpu_ovf}, 32'h0);
        chk({tag, "_ram_ctl"},   {26'h0, ram_be, ram_we, ram_rd}, 32'h0);
        chk({tag, "_ram_addr"},  {19'h0, ram_addr}, 32'h0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    endtask

    initial begin : main
        int nv;
        int nw;
        logic [31:0] last;

        // Reset state
        step(); step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Single write 0xA005 <= 0x5A
        cpu_we = 1'b1; cpu_addr = 16'hA005; cpu_din = 8'h5A;
        step();
        cpu_we = 1'b0;
        step();
        chk("wr_we",    {31'h0, ram_we}, 32'h1);
        chk("wr_addr",  {19'h0, ram_addr}, 32'h0005);
        chk("wr_be",    {28'h0, ram_be}, 32'h2);
        chk("wr_wdata", ram_wdata, 32'h5A5A5A5A);
        step();
        chk("wr_done",  {27'h0, ram_we, ram_be}, 32'h0);
        chk("wr_wdata0", ram_wdata, 32'h0);

        // Write below 0x8000 is ignored
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_din = 8'h77;
        step();
        cpu_we = 1'b0;
        step(); step();
        chk("low_ignored", {30'h0, ram_we, cpu_ovf}, 32'h0);

        // Read 0x1F00: ram_rd at N+1, vid_valid at N+4
        vid_req = 1'b1; vid_addr = 13'h1F00;
        step();
        vid_req = 1'b0;
        chk("rd_strobe", {31'h0, ram_rd}, 32'h1);
        chk("rd_addr",   {19'h0, ram_addr}, 32'h1F00);
        step();
        chk("rd_strobe_off", {31'h0, ram_rd}, 32'h0);
        step();
        chk("rd_not_yet", {31'h0, vid_valid}, 32'h0);
        step();
        chk("rd_valid", {31'h0, vid_valid}, 32'h1);
        chk("rd_data",  vid_q, 32'hDEADBEEF);
        chk("rd_nomiss", {31'h0, vid_miss}, 32'h0);
        step();
        chk("rd_valid_pulse", {31'h0, vid_valid}, 32'h0);
        chk("rd_q_held", vid_q, 32'hDEADBEEF);

        // Collision: one queued write and a request in the same IDLE cycle
        cpu_we = 1'b1; cpu_addr = 16'h8123; cpu_din = 8'h11;
        step();
        cpu_we = 1'b0; vid_req = 1'b1; vid_addr = 13'h0042;
        step();
        vid_req = 1'b0;
        chk("col_rd_first", {30'h0, ram_rd, ram_we}, 32'h2);
        step(); step(); step();
        chk("col_valid", {30'h0, vid_valid, ram_we}, 32'h2);
        chk("col_data",  vid_q, pat(13'h0042));
        step();
        chk("col_wr",       {31'h0, ram_we}, 32'h1);
        chk("col_wr_addr",  {19'h0, ram_addr}, 32'h0123);
        chk("col_wr_be",    {28'h0, ram_be}, 32'h1);
        chk("col_wr_wdata", ram_wdata, 32'h11111111);
        step();

        // Overrun: two requests one cycle apart
        vid_req = 1'b1; vid_addr = 13'h0100;
        step();
        vid_addr = 13'h0200;
        step();
        vid_req = 1'b0;
        chk("ovr_miss", {31'h0, vid_miss}, 32'h1);
        nv = 0; last = '0;
        for (int i = 0; i < 30; i++) begin
            if (vid_valid) begin nv++; last = vid_q; end
            step();
        end
        chk("ovr_nvalid", nv, 2);
        chk("ovr_last",   last, pat(13'h0200));

        // Full: five writes with vid_req every cycle; nothing drains
        vid_req = 1'b1; vid_addr = 13'h0007;
        cpu_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_addr = 16'h8000 + 16'(i);
            cpu_din  = 8'(i + 1);
            step();
            if (i == 3) begin
                chk("full_wait", {30'h0, cpu_wait, cpu_ovf}, 32'h2);
            end
        end
        cpu_we = 1'b0;
        chk("full_ovf", {30'h0, cpu_wait, cpu_ovf}, 32'h3);
        vid_req = 1'b0;
        // Drain: exactly four writes, in order, to words 0..3
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            if (ram_we) begin
                chk("drain_addr",  {19'h0, ram_addr}, 32'(nw));
                chk("drain_wdata", ram_wdata, {4{8'(nw + 1)}});
                nw++;
            end
            step();
        end
        chk("drain_count", nw, 4);
        chk("drain_wait",  {31'h0, cpu_wait}, 32'h0);
        chk("ovf_sticky",  {30'h0, cpu_ovf, vid_miss}, 32'h3);

        // Reset mid-RD with a write queued
        vid_req = 1'b1; vid_addr = 13'h0055;
        cpu_we = 1'b1; cpu_addr = 16'hC010; cpu_din = 8'h99;
        step();
        vid_req = 1'b0; cpu_we = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_rd");
        step(); step();
        reset_n = 1'b1;
        nv = 0; nw = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (vid_valid) nv++;
            if (ram_we || ram_rd) nw++;
        end
        chk("rst_no_valid", nv, 0);
        chk("rst_fifo_lost", nw, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
